// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first, carry held in a flop.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state;
    logic [WIDTH-1:0]        opa;
    logic [WIDTH-1:0]        opb;
    logic [WIDTH-1:0]        res;
    logic                    carry;
    logic [CW-1:0]           cnt;
    logic [BITS_PER_CYCLE:0] chunk;
    logic [WIDTH-1:0]        res_next;

    // One slice of the adder; chunk[MSB] is the carry into the next slice.
    assign chunk = {1'b0, opa[BITS_PER_CYCLE-1:0]}
                 + {1'b0, opb[BITS_PER_CYCLE-1:0]}
                 + {{BITS_PER_CYCLE{1'b0}}, carry};

    // Result chunks enter from the MSB end so the first chunk lands at bit 0 after N shifts.
    assign res_next = (res >> BITS_PER_CYCLE)
                    | (WIDTH'(chunk[BITS_PER_CYCLE-1:0]) << (WIDTH - BITS_PER_CYCLE));

`ifdef SERIAL_ADDER_OVF_EN
    logic cin_msb;
    assign cin_msb = opa[BITS_PER_CYCLE-1] ^ opb[BITS_PER_CYCLE-1] ^ chunk[BITS_PER_CYCLE-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        // Subtraction as a + ~b + 1: invert b here, the +1 enters via carry.
                        opb   <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    opa   <= opa >> BITS_PER_CYCLE;
                    opb   <= opb >> BITS_PER_CYCLE;
                    res   <= res_next;
                    carry <= chunk[BITS_PER_CYCLE];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= chunk[BITS_PER_CYCLE];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= cin_msb ^ chunk[BITS_PER_CYCLE];
`endif
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 1-bit slice instance plus a 4-bit slice instance.
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start4 = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       busy4, done4, cout4;
    logic [7:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf, ovf4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a), .b(b),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Launch one operation, wait (bounded) for done, check latency, result and pulse width.
    task automatic run_op(input bit w4, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic ts, input logic [7:0] esum, input logic ecout,
                          input logic eovf, input int elat, input string tag);
        int cyc;
        @(negedge clk);
        a = ta; b = tb_; sub = ts;
        if (w4) start4 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start4 = 1'b0;
        cyc = 0;
        while (cyc < 40 && !(w4 ? done4 : done)) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_sum"}, w4 ? sum4 : sum, esum);
        check({tag, "_cout"}, w4 ? cout4 : cout, ecout);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, w4 ? ovf4 : ovf, eovf);
`endif
        @(posedge clk); #1;
        check({tag, "_done_w"}, w4 ? done4 : done, 1'b0);
        check({tag, "_idle"}, w4 ? busy4 : busy, 1'b0);
    endtask

    initial begin
        int nd;
        int last;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 8, "add1");
        run_op(1'b1, 8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 2, "add4");
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, "wrap");
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8, "sovf");
        run_op(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 2, "sovf4");
        run_op(1'b0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 8, "borrow");
        run_op(1'b0, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, 8, "noborrow");
        run_op(1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 2, "borrow4");

        // start while busy is ignored; sum holds the previous result until done
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        check("busy_hold_sum", sum, 8'h02);
        @(posedge clk); #1; start = 1'b0;
        check("busy_hold_sum2", sum, 8'h02);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                check("busy_sum", sum, 8'h30);
            end
        end
        check("busy_ndone", nd, 1);
        check("busy_idle", busy, 1'b0);

        // reset mid-RUN aborts the operation
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_sum", sum, 8'h00);
        check("abort_done", done, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_nodone", nd, 0);
        run_op(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8, "post_rst");

        // start held high: one op every N+2 clocks, busy low one cycle between
        @(negedge clk);
        a = 8'h03; b = 8'h04; sub = 1'b0; start = 1'b1;
        nd = 0;
        last = -100;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk); #1;
            if (i == last + 1) check("b2b_gap_low", busy, 1'b0);
            if (i == last + 2) check("b2b_gap_high", busy, 1'b1);
            if (done) begin
                if (nd == 0) check("b2b_first", i, 8);
                else check("b2b_period", i - last, 10);
                check("b2b_sum", sum, 8'h07);
                last = i;
                nd++;
            end
        end
        check("b2b_ndone", nd, 3);
        start = 1'b0;
        repeat (15) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
